// File: rtl/issue_scheduler.sv
`default_nettype none
// ============================================================================
//  Module      : issue_scheduler
//  Description : Front-end sequencer for the entropy-encoder pipeline.
//                Buffers symbol bundles in a small FIFO, issues them into
//                stage 1 at a throttled rate, tracks per-stage occupancy,
//                raises carry_ctrl once the pipe is primed, and at end of
//                frame drains the pipe and runs the flush handshake with
//                the final bit-packer.
//  Revision    : 1.0 - initial release
// ============================================================================
module issue_scheduler #(
    parameter int DATA_W     = 32,
    parameter int FIFO_DEPTH = 4,
    parameter int ISSUE_GAP  = 1,
    parameter int PIPE_DEPTH = 3
) (
    input  logic                  clk,
    input  logic                  reset_ctrl,
    input  logic                  enable,
    input  logic                  s_valid,
    output logic                  s_ready,
    input  logic [DATA_W-1:0]     s_data,
    input  logic                  s_last,
    output logic                  issue_valid,
    output logic [DATA_W-1:0]     issue_data,
    output logic                  issue_last,
    output logic [PIPE_DEPTH-1:0] stage_valid,
    output logic                  carry_ctrl,
    output logic                  flush_req,
    input  logic                  flush_ack,
    output logic                  frame_done,
    output logic                  busy
);

    localparam int c_ADDR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int c_GAP_W  = (ISSUE_GAP > 0) ? $clog2(ISSUE_GAP + 1) : 1;

    localparam logic [c_GAP_W-1:0]  c_GAP_LOAD  = c_GAP_W'(ISSUE_GAP);
    localparam logic [c_GAP_W-1:0]  c_GAP_ONE   = c_GAP_W'(1);
    localparam logic [c_ADDR_W-1:0] c_PTR_ONE   = c_ADDR_W'(1);
    localparam logic [c_ADDR_W:0]   c_CNT_ONE   = (c_ADDR_W + 1)'(1);
    localparam logic [c_ADDR_W:0]   c_CNT_FULL  = (c_ADDR_W + 1)'(FIFO_DEPTH);

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_DRAIN = 2'd1,
        ST_FLUSH = 2'd2
    } state_t;

    state_t r_state;
    state_t w_state_next;

    // FIFO storage: each entry is {last, data}
    logic [DATA_W:0]         r_mem [FIFO_DEPTH];
    logic [c_ADDR_W-1:0]     r_wr_ptr;
    logic [c_ADDR_W-1:0]     r_rd_ptr;
    logic [c_ADDR_W:0]       r_count;
    logic [c_GAP_W-1:0]      r_gap_cnt;

    logic                    w_fifo_empty;
    logic                    w_fifo_full;
    logic                    w_push;
    logic                    w_issue_fire;
    logic [DATA_W:0]         w_head;
    logic                    w_ack_take;
    logic [PIPE_DEPTH-1:0]   w_stage_next;

    assign w_fifo_empty = (r_count == '0);
    assign w_fifo_full  = (r_count == c_CNT_FULL);
    assign w_push       = s_valid && !w_fifo_full;
    assign w_head       = r_mem[r_rd_ptr];

    // An issue needs RUN, permission, a queued bundle and an expired gap timer
    assign w_issue_fire = (r_state == ST_RUN) && enable && !w_fifo_empty
                          && (r_gap_cnt == '0);

    assign s_ready     = !w_fifo_full;
    assign issue_valid = stage_valid[0];
    assign busy        = (r_state != ST_RUN) || !w_fifo_empty || (|stage_valid);

    // FIFO data array; contents need no reset since pointers define validity
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= {s_last, s_data};
        end
    end

    // FIFO pointers and occupancy count; depth is a power of two so pointers wrap naturally
    always_ff @(posedge clk) begin
        if (reset_ctrl) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + c_PTR_ONE;
            end
            if (w_issue_fire) begin
                r_rd_ptr <= r_rd_ptr + c_PTR_ONE;
            end
            case ({w_push, w_issue_fire})
                2'b10:   r_count <= r_count + c_CNT_ONE;
                2'b01:   r_count <= r_count - c_CNT_ONE;
                default: r_count <= r_count;
            endcase
        end
    end

    // Issue throttle: reload on issue, count down every cycle, cleared on frame completion
    always_ff @(posedge clk) begin
        if (reset_ctrl) begin
            r_gap_cnt <= '0;
        end else if (w_ack_take) begin
            r_gap_cnt <= '0;
        end else if (w_issue_fire) begin
            r_gap_cnt <= c_GAP_LOAD;
        end else if (r_gap_cnt != '0) begin
            r_gap_cnt <= r_gap_cnt - c_GAP_ONE;
        end
    end

    // Registered issue payload, loaded only when a bundle leaves the FIFO
    always_ff @(posedge clk) begin
        if (reset_ctrl) begin
            issue_data <= '0;
            issue_last <= 1'b0;
        end else if (w_issue_fire) begin
            issue_data <= w_head[DATA_W-1:0];
            issue_last <= w_head[DATA_W];
        end
    end

    // Next occupancy vector: stage 0 takes the issue, the rest shift unconditionally
    always_comb begin
        w_stage_next    = '0;
        w_stage_next[0] = w_issue_fire;
        for (int i = 1; i < PIPE_DEPTH; i++) begin
            w_stage_next[i] = stage_valid[i-1];
        end
    end

    // Occupancy shift register
    always_ff @(posedge clk) begin
        if (reset_ctrl) begin
            stage_valid <= '0;
        end else begin
            stage_valid <= w_stage_next;
        end
    end

    // carry_ctrl latches when the last stage first fills and holds until the frame completes
    always_ff @(posedge clk) begin
        if (reset_ctrl) begin
            carry_ctrl <= 1'b0;
        end else if (w_ack_take) begin
            carry_ctrl <= 1'b0;
        end else if (w_stage_next[PIPE_DEPTH-1]) begin
            carry_ctrl <= 1'b1;
        end
    end

    // FSM state register
    always_ff @(posedge clk) begin
        if (reset_ctrl) begin
            r_state <= ST_RUN;
        end else begin
            r_state <= w_state_next;
        end
    end

    // FSM next-state: stop issuing after a last bundle, wait for an empty pipe, then handshake
    always_comb begin
        w_state_next = r_state;
        w_ack_take   = 1'b0;
        case (r_state)
            ST_RUN: begin
                if (w_issue_fire && w_head[DATA_W]) begin
                    w_state_next = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (stage_valid == '0) begin
                    w_state_next = ST_FLUSH;
                end
            end
            ST_FLUSH: begin
                // An ack only counts while the request is actually up
                if (flush_req && flush_ack) begin
                    w_state_next = ST_RUN;
                    w_ack_take   = 1'b1;
                end
            end
            default: begin
                w_state_next = ST_RUN;
            end
        endcase
    end

    // Flush request tracks FLUSH occupancy; frame_done pulses on the accepted ack
    always_ff @(posedge clk) begin
        if (reset_ctrl) begin
            flush_req  <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            flush_req  <= (w_state_next == ST_FLUSH);
            frame_done <= w_ack_take;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_issue_scheduler.sv
`default_nettype none
// ============================================================================
//  Module      : tb_issue_scheduler
//  Description : Scoreboard bench for issue_scheduler. Two instances: the
//                default build (ISSUE_GAP=1) and a full-rate build
//                (ISSUE_GAP=0). Accepted bundles are queued as expected
//                issues; monitors pop and compare on every issue_valid.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_issue_scheduler;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic reset_ctrl = 1'b1;

    // default build
    logic        enable = 1'b1, s_valid = 1'b0, s_last = 1'b0, flush_ack = 1'b0;
    logic [31:0] s_data = '0;
    logic        s_ready, issue_valid, issue_last, carry_ctrl, flush_req, frame_done, busy;
    logic [31:0] issue_data;
    logic [2:0]  stage_valid;

    // full-rate build
    logic        enable_b = 1'b1, s_valid_b = 1'b0, s_last_b = 1'b0, flush_ack_b = 1'b0;
    logic [31:0] s_data_b = '0;
    logic        s_ready_b, issue_valid_b, issue_last_b, carry_ctrl_b, flush_req_b, frame_done_b, busy_b;
    logic [31:0] issue_data_b;
    logic [2:0]  stage_valid_b;

    issue_scheduler #(.DATA_W(32), .FIFO_DEPTH(4), .ISSUE_GAP(1), .PIPE_DEPTH(3)) dut (
        .clk(clk), .reset_ctrl(reset_ctrl), .enable(enable),
        .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data), .s_last(s_last),
        .issue_valid(issue_valid), .issue_data(issue_data), .issue_last(issue_last),
        .stage_valid(stage_valid), .carry_ctrl(carry_ctrl), .flush_req(flush_req),
        .flush_ack(flush_ack), .frame_done(frame_done), .busy(busy)
    );

    issue_scheduler #(.DATA_W(32), .FIFO_DEPTH(4), .ISSUE_GAP(0), .PIPE_DEPTH(3)) dut_b (
        .clk(clk), .reset_ctrl(reset_ctrl), .enable(enable_b),
        .s_valid(s_valid_b), .s_ready(s_ready_b), .s_data(s_data_b), .s_last(s_last_b),
        .issue_valid(issue_valid_b), .issue_data(issue_data_b), .issue_last(issue_last_b),
        .stage_valid(stage_valid_b), .carry_ctrl(carry_ctrl_b), .flush_req(flush_req_b),
        .flush_ack(flush_ack_b), .frame_done(frame_done_b), .busy(busy_b)
    );

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    logic [32:0] sb_a[$];
    logic [32:0] sb_b[$];

    always @(posedge clk) cyc++;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual %0h required %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic fail_now(input string name);
        n_checks++;
        n_fail++;
        $display("FAIL %s: bound expired or unexpected event (cycle %0d)", name, cyc);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present one bundle and hold it until the handshake completes
    task automatic send(input int which, input logic [31:0] d, input logic l);
        int   waited;
        bit   done;
        logic rdy;
        waited = 0;
        done   = 0;
        if (which == 0) begin s_valid = 1'b1; s_data = d; s_last = l; end
        else begin s_valid_b = 1'b1; s_data_b = d; s_last_b = l; end
        while (!done) begin
            @(negedge clk);
            rdy = (which == 0) ? s_ready : s_ready_b;
            @(posedge clk);
            #1;
            if (rdy) begin
                done = 1;
                if (which == 0) sb_a.push_back({l, d});
                else            sb_b.push_back({l, d});
            end else begin
                waited++;
                if (waited > 40) begin
                    fail_now("send_timeout");
                    done = 1;
                end
            end
        end
    endtask

    task automatic wait_sb(input int which);
        int n;
        n = 0;
        while (((which == 0) ? sb_a.size() : sb_b.size()) != 0 && n < 80) begin
            tick();
            n++;
        end
        if (n >= 80) fail_now("drain_timeout");
    endtask

    // Monitor for the default build: order, spacing and carry timing
    bit prev_iv_a    = 1'b0;
    bit prev_carry_a = 1'b0;
    int first_iss    = -1;
    always @(negedge clk) begin
        logic [32:0] exp;
        if (reset_ctrl) begin
            first_iss = -1;
        end else begin
            if (issue_valid) begin
                check("issue_spacing", {63'b0, prev_iv_a}, 64'd0);
                if (sb_a.size() == 0) begin
                    fail_now("unexpected_issue");
                end else begin
                    exp = sb_a.pop_front();
                    check("issue_bundle", {31'b0, issue_last, issue_data}, {31'b0, exp});
                end
                if (!carry_ctrl && first_iss < 0) first_iss = cyc;
            end
            if (carry_ctrl && !prev_carry_a) begin
                if (first_iss < 0) fail_now("carry_without_issue");
                else check("carry_rise_delay", 64'(cyc - first_iss), 64'd2);
                first_iss = -1;
            end
        end
        prev_iv_a    = issue_valid;
        prev_carry_a = carry_ctrl;
    end

    // Monitor for the full-rate build: order plus back-to-back run length
    int run_b       = 0;
    int max_run_b   = 0;
    bit seen_full_b = 1'b0;
    always @(negedge clk) begin
        logic [32:0] exp;
        if (!reset_ctrl) begin
            if (issue_valid_b) begin
                if (sb_b.size() == 0) begin
                    fail_now("unexpected_issue_b");
                end else begin
                    exp = sb_b.pop_front();
                    check("issue_bundle_b", {31'b0, issue_last_b, issue_data_b}, {31'b0, exp});
                end
                run_b++;
                if (run_b > max_run_b) max_run_b = run_b;
            end else begin
                run_b = 0;
            end
            if (stage_valid_b == 3'b111) seen_full_b = 1'b1;
        end
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int iss_cnt;

        // ---------------- reset ----------------
        tick();
        tick();
        @(negedge clk);
        check("rst_issue_valid", issue_valid, 0);
        check("rst_issue_data",  issue_data, 0);
        check("rst_stage_valid", stage_valid, 0);
        check("rst_carry",       carry_ctrl, 0);
        check("rst_flush_req",   flush_req, 0);
        check("rst_frame_done",  frame_done, 0);
        check("rst_busy",        busy, 0);
        check("rst_s_ready",     s_ready, 1);
        check("rst_s_ready_b",   s_ready_b, 1);
        @(posedge clk); #1;
        reset_ctrl = 1'b0;
        repeat (5) begin
            @(negedge clk);
            check("idle_busy", busy, 0);
        end

        // ---------------- first-issue latency, then streaming ----------------
        tick();
        send(0, 32'h10, 1'b0);
        s_valid = 1'b0;
        @(negedge clk);
        check("latency_early", issue_valid, 0);
        @(negedge clk);
        check("latency_first", issue_valid, 1);
        tick();
        for (int i = 1; i < 6; i++) send(0, 32'h10 + 32'(i), 1'b0);
        s_valid = 1'b0;
        wait_sb(0);
        repeat (4) tick();
        @(negedge clk);
        check("stream_carry_sticky", carry_ctrl, 1);
        check("stream_idle_busy",    busy, 0);
        check("stream_stage_empty",  stage_valid, 0);

        // ---------------- enable low: FIFO fills, pipe empties ----------------
        tick();
        enable = 1'b0;
        for (int i = 0; i < 4; i++) send(0, 32'h20 + 32'(i), 1'b0);
        s_valid = 1'b0;
        @(negedge clk);
        check("hold_s_ready",    s_ready, 0);
        check("hold_stage",      stage_valid, 0);
        check("hold_carry",      carry_ctrl, 1);
        check("hold_busy",       busy, 1);
        repeat (2) begin
            @(negedge clk);
            check("hold_no_issue", issue_valid, 0);
        end
        @(posedge clk); #1;
        enable = 1'b1;
        wait_sb(0);
        tick();

        // ---------------- end of frame: drain, flush, resume ----------------
        send(0, 32'h31, 1'b0);
        send(0, 32'h32, 1'b0);
        send(0, 32'h33, 1'b1);
        send(0, 32'h34, 1'b0);
        send(0, 32'h35, 1'b0);
        s_valid = 1'b0;
        s_last  = 1'b0;
        n = 0;
        iss_cnt = 0;
        @(negedge clk);
        while (!flush_req && n < 40) begin
            if (issue_valid) iss_cnt++;
            @(negedge clk);
            n++;
        end
        if (n >= 40) fail_now("flush_req_timeout");
        check("drain_issue_count", 64'(iss_cnt), 64'd1);
        check("flush_stage_empty", stage_valid, 0);
        check("flush_busy",        busy, 1);
        check("flush_carry_held",  carry_ctrl, 1);
        check("flush_no_issue",    issue_valid, 0);
        repeat (4) begin
            @(negedge clk);
            check("flush_req_hold",  flush_req, 1);
            check("flush_no_done",   frame_done, 0);
        end
        @(posedge clk); #1;
        flush_ack = 1'b1;
        @(posedge clk); #1;
        flush_ack = 1'b0;
        @(negedge clk);
        check("ack_frame_done", frame_done, 1);
        check("ack_flush_req",  flush_req, 0);
        check("ack_carry_clr",  carry_ctrl, 0);
        check("ack_no_issue",   issue_valid, 0);
        @(negedge clk);
        check("done_pulse_end", frame_done, 0);
        check("resume_issue",   issue_valid, 1);
        check("resume_data",    issue_data, 32'h34);
        wait_sb(0);
        tick();

        // ---------------- reset while flushing ----------------
        send(0, 32'h41, 1'b1);
        send(0, 32'h42, 1'b0);
        s_valid = 1'b0;
        s_last  = 1'b0;
        n = 0;
        @(negedge clk);
        while (!flush_req && n < 40) begin
            @(negedge clk);
            n++;
        end
        if (n >= 40) fail_now("flush_req_timeout_2");
        check("pre_reset_carry", carry_ctrl, 1);
        check("pre_reset_fifo",  busy, 1);
        @(posedge clk); #1;
        reset_ctrl = 1'b1;
        sb_a.delete();
        @(posedge clk); #1;
        reset_ctrl = 1'b0;
        @(negedge clk);
        check("mid_rst_flush_req", flush_req, 0);
        check("mid_rst_s_ready",   s_ready, 1);
        check("mid_rst_carry",     carry_ctrl, 0);
        check("mid_rst_busy",      busy, 0);
        check("mid_rst_stage",     stage_valid, 0);
        @(posedge clk); #1;
        flush_ack = 1'b1;
        @(posedge clk); #1;
        flush_ack = 1'b0;
        repeat (3) begin
            @(negedge clk);
            check("late_ack_no_done", frame_done, 0);
            check("late_ack_no_req",  flush_req, 0);
            check("late_ack_busy",    busy, 0);
        end
        tick();

        // ---------------- full-rate build ----------------
        for (int i = 0; i < 4; i++) send(1, 32'hA0 + 32'(i), 1'b0);
        s_valid_b = 1'b0;
        wait_sb(1);
        repeat (3) tick();
        check("fullrate_run",   64'(max_run_b), 64'd4);
        check("fullrate_stage", {63'b0, seen_full_b}, 64'd1);
        check("fullrate_carry", carry_ctrl_b, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/issue_scheduler.md
Name: issue_scheduler

Overview:
Front-end sequencer for the entropy-encoder pipeline. Buffers incoming symbol bundles and issues them into stage 1 at a throttled rate, one bundle every ISSUE_GAP+1 cycles, to cover the stage-2/stage-3 range dependency. Tracks per-stage occupancy and drives carry_ctrl once the pipe is primed. At end of frame it drains the pipe and runs a flush handshake with the final bit-packer.

Parameters:
DATA_W, 32, width of one symbol bundle (symbol, cdf and nsyms packed by the caller)
FIFO_DEPTH, 4, input buffer entries; power of 2, >= 2
ISSUE_GAP, 1, idle cycles forced between consecutive issues; 0 gives full rate
PIPE_DEPTH, 3, number of encoder pipeline stages tracked

Ports:
clk  in  1  clock
reset_ctrl  in  1  synchronous active-high reset
enable  in  1  issue permission; 0 stalls new issues only
s_valid  in  1  input bundle valid
s_ready  out  1  input ready; equals !fifo_full
s_data  in  DATA_W  input bundle
s_last  in  1  bundle is last of frame
issue_valid  out  1  bundle presented to stage 1 this cycle; equals stage_valid[0]
issue_data  out  DATA_W  issued bundle, registered
issue_last  out  1  last flag of issued bundle
stage_valid  out  PIPE_DEPTH  occupancy shift register per stage
carry_ctrl  out  1  pipe primed; stage 3 feedback valid
flush_req  out  1  request final flush to bit-packer
flush_ack  in  1  bit-packer flush complete
frame_done  out  1  one-cycle pulse at frame completion
busy  out  1  any work pending or in flight

Behaviour:
- Reset (reset_ctrl high at a clk edge) clears everything: FIFO empty, state RUN, gap_cnt 0, all outputs 0 except s_ready=1. Applies mid-operation, including during DRAIN/FLUSH; flush_req drops at that edge.
- FIFO: stores {s_last,s_data}. Push when s_valid && s_ready. No push when full, no bypass path. Pointers wrap modulo FIFO_DEPTH. Push and pop in the same cycle are both allowed.
- gap_cnt: loads ISSUE_GAP on each issue and decrements toward 0 every cycle regardless of enable.
- Issue condition, evaluated per cycle: state==RUN && enable && fifo not empty && gap_cnt==0. On issue the FIFO head pops, and issue_data/issue_last/stage_valid[0] are registered at that edge.
- Latency: a bundle pushed into an empty FIFO at edge t appears on issue_valid during the cycle after edge t+1 at the earliest.
- stage_valid[0] <= issue fire; stage_valid[i] <= stage_valid[i-1]. Shifting is free-running and is not stalled by enable.
- carry_ctrl: 0 after reset. Set at the edge where stage_valid[PIPE_DEPTH-1] first registers 1. Sticky until frame completion or reset.
- FSM states: RUN, DRAIN, FLUSH.
  - RUN -> DRAIN when a bundle with last=1 is issued. No further issues until back in RUN; the FIFO keeps accepting input.
  - DRAIN -> FLUSH when stage_valid is all zero.
  - In FLUSH, flush_req is registered high and held until flush_ack is sampled high while flush_req=1. flush_ack while flush_req=0 is ignored.
  - FLUSH -> RUN on ack. On that edge: frame_done=1 for exactly one cycle, flush_req=0, carry_ctrl=0, gap_cnt=0.
  - The next frame's first issue can occur in the cycle after return to RUN.
- busy = state!=RUN || fifo not empty || |stage_valid.
- Enable low in DRAIN/FLUSH has no effect on drain or flush progress.

Test Plan:
- Reset: hold reset_ctrl 2 cycles -> all outputs 0, s_ready=1. Then s_valid=0 for 5 cycles -> busy stays 0.
- Default params, 6 bundles 0x10..0x15 with s_valid held high:
  - issue_valid high every second cycle, in order.
  - s_ready drops when 4 entries are queued.
  - carry_ctrl rises exactly 2 cycles after the first issue_valid and stays 1.
- ISSUE_GAP=0 build, 4 bundles -> issue_valid high on 4 consecutive cycles; stage_valid reaches 3'b111.
- s_last on bundle 3 with bundles 4,5 queued:
  - bundle 3 issued; no issue while stage_valid clears (3 cycles).
  - flush_req rises; ack driven 5 cycles later -> frame_done one-cycle pulse, carry_ctrl=0.
  - bundle 4 issued the next cycle.
- enable low for 4 cycles mid-stream -> no issue_valid, stage_valid shifts to 0, carry_ctrl stays 1, FIFO fills to 4 and s_ready=0. Issues resume in order after enable returns.
- reset_ctrl pulsed while flush_req=1 -> next cycle flush_req=0, FIFO empty, carry_ctrl=0, busy=0. A late flush_ack produces no frame_done.
